// File: rtl/uart_alu_interface.sv
// Frame sequencer between the UART FIFOs and an external combinational ALU.
// Pops A, B and OP bytes, runs the ALU for one cycle and pushes the result byte.
module uart_alu_interface #(
  parameter int unsigned DBIT   = 8,
  parameter int unsigned OP_W   = 6,
  parameter int unsigned TO_CYC = 50000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  output logic [DBIT-1:0] alu_a,
  output logic [DBIT-1:0] alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [DBIT-1:0] alu_result,
  output logic            frame_err,
  output logic            busy
);

  typedef enum logic [2:0] {StGetA, StGetB, StGetOp, StExec, StSend} state_e;

  localparam logic [31:0] ToLast = 32'(TO_CYC) - 32'd1;

  state_e          state_q;
  logic [DBIT-1:0] a_q, b_q, res_q;
  logic [OP_W-1:0] op_q;
  logic [31:0]     to_cnt_q;
  logic            ferr_q;
  logic            in_get, to_arm, expire;

  always_comb begin
    in_get  = (state_q == StGetA) || (state_q == StGetB) || (state_q == StGetOp);
    rd_uart = ~reset & in_get & ~rx_empty;
    wr_uart = ~reset & (state_q == StSend) & ~tx_full;
    // Only a partially received frame is subject to the inter-byte timeout.
    to_arm  = (TO_CYC != 0) && ((state_q == StGetB) || (state_q == StGetOp)) && rx_empty;
    expire  = to_arm && (to_cnt_q == ToLast);
    alu_a     = a_q;
    alu_b     = b_q;
    alu_op    = op_q;
    w_data    = res_q;
    frame_err = ferr_q;
    busy      = (state_q != StGetA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StGetA;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      to_cnt_q <= '0;
      ferr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      unique case (state_q)
        StGetA: begin
          to_cnt_q <= '0;
          if (!rx_empty) begin
            a_q     <= r_data;
            state_q <= StGetB;
          end
        end
        StGetB: begin
          if (!rx_empty) begin
            b_q      <= r_data;
            state_q  <= StGetOp;
            to_cnt_q <= '0;
          end else if (expire) begin
            state_q  <= StGetA;
            to_cnt_q <= '0;
            ferr_q   <= 1'b1;
          end else if (to_arm) begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
        end
        StGetOp: begin
          if (!rx_empty) begin
            op_q     <= r_data[OP_W-1:0];
            state_q  <= StExec;
            to_cnt_q <= '0;
          end else if (expire) begin
            state_q  <= StGetA;
            to_cnt_q <= '0;
            ferr_q   <= 1'b1;
          end else if (to_arm) begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
        end
        StExec: begin
          res_q   <= alu_result;
          state_q <= StSend;
        end
        StSend: begin
          if (!tx_full) state_q <= StGetA;
        end
        default: state_q <= StGetA;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: FIFO and ALU models, directed frames and randomized traffic
// checked against a frame-level expected-result queue.
module tb_uart_alu_interface;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty = 1'b1;
  logic       tx_full = 1'b0;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart, wr_uart, frame_err, busy;
  logic [7:0] w_data, alu_a, alu_b, alu_result;
  logic [5:0] alu_op;

  int checks = 0;
  int failures = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int pop_cyc_q[$];
  int wr_cyc_q[$];
  int cyc = 0;
  int pop_cnt = 0;
  int push_cnt = 0;
  int ferr_cnt = 0;
  bit rand_tx = 1'b0;

  uart_alu_interface #(.DBIT(8), .OP_W(6), .TO_CYC(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_empty   (rx_empty),
    .r_data     (r_data),
    .rd_uart    (rd_uart),
    .tx_full    (tx_full),
    .wr_uart    (wr_uart),
    .w_data     (w_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b, logic [5:0] op);
    if (op == 6'h20) return a + b;
    if (op == 6'h22) return a - b;
    return a ^ b;
  endfunction

  always_comb alu_result = alu_f(alu_a, alu_b, alu_op);

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    rx_empty = (rx_q.size() == 0);
    r_data   = rx_empty ? 8'h00 : rx_q[0];
  endtask

  task automatic tick();
    bit pop_now;
    @(negedge clk);
    cyc++;
    check("rd_while_empty", 32'(rd_uart & rx_empty), 0);
    check("wr_while_full", 32'(wr_uart & tx_full), 0);
    if (wr_uart) begin
      if (exp_q.size() == 0) check("spurious_push", 32'(wr_uart), 0);
      else check("w_data", 32'(w_data), 32'(exp_q.pop_front()));
      push_cnt++;
      wr_cyc_q.push_back(cyc);
    end
    if (frame_err) ferr_cnt++;
    pop_now = rd_uart;
    if (pop_now) begin
      pop_cnt++;
      pop_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (pop_now && rx_q.size() != 0) void'(rx_q.pop_front());
    if (rand_tx) tx_full = ($urandom_range(0, 3) == 0);
    drive();
  endtask

  task automatic push_byte(logic [7:0] b);
    rx_q.push_back(b);
    drive();
  endtask

  task automatic push_frame(logic [7:0] a, logic [7:0] b, logic [7:0] op, int gap_max);
    exp_q.push_back(alu_f(a, b, op[5:0]));
    push_byte(a);
    repeat ($urandom_range(0, gap_max)) tick();
    push_byte(b);
    repeat ($urandom_range(0, gap_max)) tick();
    push_byte(op);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 400 && (exp_q.size() != 0 || rx_q.size() != 0); i++) tick();
    check("drain_timeout", exp_q.size() + rx_q.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    int p0, f0;
    logic [7:0] op;

    // Reset state
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_rd", 32'(rd_uart), 0);
    check("rst_wr", 32'(wr_uart), 0);
    reset = 1'b0;
    tick();
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_alu_b", 32'(alu_b), 0);
    check("rst_alu_op", 32'(alu_op), 0);
    check("rst_w_data", 32'(w_data), 0);
    check("rst_ferr", 32'(frame_err), 0);

    // 1: single frame, latency
    pop_cyc_q.delete(); wr_cyc_q.delete();
    p0 = push_cnt;
    exp_q.push_back(8'h08);
    push_byte(8'h05); push_byte(8'h03); push_byte(8'h20);
    drain();
    check("t1_alu_a", 32'(alu_a), 32'h05);
    check("t1_alu_b", 32'(alu_b), 32'h03);
    check("t1_alu_op", 32'(alu_op), 32'h20);
    check("t1_pops", pop_cyc_q.size(), 3);
    check("t1_pushes", push_cnt - p0, 1);
    if (pop_cyc_q.size() == 3 && wr_cyc_q.size() == 1) begin
      check("t1_pop_span", pop_cyc_q[2] - pop_cyc_q[0], 2);
      check("t1_latency", wr_cyc_q[0] - pop_cyc_q[2], 2);
    end

    // 2: two back-to-back frames
    wr_cyc_q.delete();
    p0 = push_cnt;
    exp_q.push_back(8'h05); exp_q.push_back(8'h00);
    push_byte(8'h09); push_byte(8'h04); push_byte(8'h22);
    push_byte(8'hFF); push_byte(8'h01); push_byte(8'h20);
    drain();
    check("t2_pushes", push_cnt - p0, 2);
    if (wr_cyc_q.size() == 2) check("t2_period", wr_cyc_q[1] - wr_cyc_q[0], 5);

    // 3: back-pressure
    p0 = push_cnt;
    tx_full = 1'b1;
    exp_q.push_back(8'h02);
    push_byte(8'h01); push_byte(8'h01); push_byte(8'h20);
    repeat (10) tick();
    check("t3_busy", 32'(busy), 1);
    check("t3_no_push", push_cnt - p0, 0);
    tx_full = 1'b0;
    drain();
    check("t3_pushes", push_cnt - p0, 1);

    // 4: timeout after A only
    p0 = push_cnt; f0 = ferr_cnt;
    push_byte(8'h07);
    repeat (22) tick();
    check("t4_ferr", ferr_cnt - f0, 1);
    check("t4_idle", 32'(busy), 0);
    check("t4_no_push", push_cnt - p0, 0);
    exp_q.push_back(8'h05);
    push_byte(8'h02); push_byte(8'h03); push_byte(8'h20);
    drain();
    check("t4_pushes", push_cnt - p0, 1);

    // 5: reset mid-frame, queued bytes become a fresh frame
    p0 = push_cnt; f0 = pop_cnt;
    push_byte(8'hA1); push_byte(8'hB2);
    for (int i = 0; i < 20 && pop_cnt - f0 < 2; i++) tick();
    check("t5_pops", pop_cnt - f0, 2);
    exp_q.push_back(alu_f(8'h30, 8'h11, 6'h22));
    rx_q.push_back(8'h30); rx_q.push_back(8'h11); rx_q.push_back(8'h22);
    reset = 1'b1;
    drive();
    #1;
    check("t5_rd_in_reset", 32'(rd_uart), 0);
    tick();
    reset = 1'b0;
    #1;
    check("t5_alu_a", 32'(alu_a), 0);
    check("t5_alu_b", 32'(alu_b), 0);
    check("t5_alu_op", 32'(alu_op), 0);
    check("t5_w_data", 32'(w_data), 0);
    check("t5_busy", 32'(busy), 0);
    drain();
    check("t5_pushes", push_cnt - p0, 1);

    // 6: upper opcode bits ignored
    exp_q.push_back(8'h11);
    push_byte(8'h10); push_byte(8'h01); push_byte(8'hE0);
    drain();
    check("t6_alu_op", 32'(alu_op), 32'h20);

    // Randomized frames with gaps and random back-pressure
    p0 = push_cnt; f0 = ferr_cnt;
    rand_tx = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: op = 8'h20;
        1: op = 8'h22;
        2: op = 8'hE2;
        default: op = 8'($urandom);
      endcase
      push_frame(8'($urandom), 8'($urandom), op, 5);
      repeat ($urandom_range(0, 4)) tick();
    end
    drain();
    rand_tx = 1'b0;
    tx_full = 1'b0;
    drain();
    check("rnd_pushes", push_cnt - p0, 40);
    check("rnd_no_ferr", ferr_cnt - f0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
